// File: rtl/fc_logit_producer_pkg.sv
// rtl/fc_logit_producer_pkg.sv - shared logit-vector constants, FSM states and saturation helper
package fc_logit_producer_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int LOGIT_W     = 18;
  localparam int LOGIT_VEC_W = NUM_CLASSES * LOGIT_W;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (LOGIT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (LOGIT_W - 1));

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_BIAS  = 2'd1,
    ST_OUT   = 2'd2
  } fc_state_t;

  // Callers sign-extend into 64 bits so one helper serves every layer width.
  function automatic logic signed [LOGIT_W-1:0] sat_logit(input logic signed [63:0] x);
    if (x > SAT_MAX)
      return SAT_MAX[LOGIT_W-1:0];
    else if (x < SAT_MIN)
      return SAT_MIN[LOGIT_W-1:0];
    else
      return x[LOGIT_W-1:0];
  endfunction

endpackage

// File: rtl/fc_logit_producer_mac_lane.sv
// rtl/fc_logit_producer_mac_lane.sv - one signed multiply-accumulate lane with clear and enable
module fc_mac_lane #(
  parameter int DW    = 18,
  parameter int WW    = 16,
  parameter int ACC_W = 42
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    feat,
  input  logic signed [WW-1:0]    weight,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [DW+WW-1:0] prod;

  assign prod = feat * weight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + {{(ACC_W-DW-WW){prod[DW+WW-1]}}, prod};
  end

endmodule

// File: rtl/fc_logit_producer.sv
// rtl/fc_logit_producer.sv - final FC layer: serial features in, 10 saturated logits out
module fc_logit_producer
  import fc_logit_producer_pkg::*;
#(
  parameter int N_IN = 84,
  parameter int DW   = 18,
  parameter int WW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DW-1:0]        in_data,
  output logic [AW-1:0]               w_addr,
  input  logic [NUM_CLASSES*WW-1:0]   w_data,
  output logic [LOGIT_VEC_W-1:0]      dout,
  output logic                        enable
);

  localparam int ACC_W = DW + WW + $clog2(N_IN) + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);
  localparam logic [AW-1:0] BIAS_IDX = AW'(N_IN);

  fc_state_t             state, state_n;
  logic [AW-1:0]         cnt;
  logic                  alive;
  logic                  accept;
  logic                  p_valid;
  logic signed [DW-1:0]  p_feat;
  logic                  clr;
  logic [LOGIT_VEC_W-1:0] logit_vec;

  // alive keeps in_ready low until the first edge after reset release.
  assign in_ready = alive && (state == ST_ACCUM);
  assign accept   = in_valid && in_ready;
  assign clr      = (state == ST_OUT);

  always_comb begin
    state_n = state;
    w_addr  = cnt;
    unique case (state)
      ST_ACCUM: begin
        if (in_valid && alive && cnt == LAST_IDX)
          state_n = ST_BIAS;
      end
      ST_BIAS: begin
        w_addr  = BIAS_IDX;
        state_n = ST_OUT;
      end
      ST_OUT: begin
        w_addr  = BIAS_IDX;
        state_n = ST_ACCUM;
      end
      default: state_n = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACCUM;
      cnt     <= '0;
      alive   <= 1'b0;
      p_valid <= 1'b0;
      p_feat  <= '0;
      dout    <= '0;
      enable  <= 1'b0;
    end else begin
      state   <= state_n;
      alive   <= 1'b1;
      p_valid <= accept;
      if (accept)
        p_feat <= in_data;
      if (clr)
        cnt <= '0;
      else if (accept)
        cnt <= cnt + 1'b1;
      enable <= clr;
      if (clr)
        dout <= logit_vec;
    end
  end

  // The same w_data slice carries the feature weight in ACCUM and the bias in OUT.
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    logic signed [WW-1:0]    wk;
    logic signed [ACC_W-1:0] acc_k;
    logic signed [ACC_W:0]   sum_k;
    logic signed [ACC_W:0]   shr_k;

    assign wk = w_data[(NUM_CLASSES-1-k)*WW +: WW];

    fc_mac_lane #(
      .DW    (DW),
      .WW    (WW),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .en     (p_valid),
      .feat   (p_feat),
      .weight (wk),
      .acc    (acc_k)
    );

    assign sum_k = {acc_k[ACC_W-1], acc_k} + {{(ACC_W+1-WW){wk[WW-1]}}, wk};
    assign shr_k = sum_k >>> FRAC;
    assign logit_vec[(NUM_CLASSES-1-k)*LOGIT_W +: LOGIT_W] =
      sat_logit({{(63-ACC_W){shr_k[ACC_W]}}, shr_k});
  end

endmodule

// File: tb/tb_fc_logit_producer.sv
// tb/tb_fc_logit_producer.sv - directed table-driven bench for fc_logit_producer
module tb_fc_logit_producer;

  localparam int N  = 4;
  localparam int AW = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [17:0]  in_data = '0;
  logic                in_ready0, in_ready2;
  logic [AW-1:0]       wa0, wa2;
  logic [159:0]        wd0 = '0, wd2 = '0;
  logic [179:0]        dout0, dout2;
  logic                en0, en2;
  logic [159:0]        rom [8];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wd0 <= rom[wa0];
    wd2 <= rom[wa2];
  end

  fc_logit_producer #(.N_IN(N), .DW(18), .WW(16), .FRAC(0), .AW(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .w_addr(wa0), .w_data(wd0), .dout(dout0), .enable(en0)
  );

  fc_logit_producer #(.N_IN(N), .DW(18), .WW(16), .FRAC(2), .AW(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .w_addr(wa2), .w_data(wd2), .dout(dout2), .enable(en2)
  );

  typedef struct {
    logic [3:0][17:0] feat;
    logic [9:0][15:0] wt;
    logic [9:0][15:0] bias;
    bit               use2;
    logic [9:0][17:0] expv;
  } vec_t;

  vec_t vecs[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkv(input string name, input logic [179:0] act, input logic [179:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [179:0] pack(input logic [9:0][17:0] e);
    logic [179:0] v;
    for (int k = 0; k < 10; k++) v[(9-k)*18 +: 18] = e[k];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom(input vec_t v);
    for (int r = 0; r < 8; r++) rom[r] = '0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 10; k++) rom[r][(9-k)*16 +: 16] = v.wt[k];
    for (int k = 0; k < 10; k++) rom[N][(9-k)*16 +: 16] = v.bias[k];
  endtask

  task automatic offer(input logic [17:0] f);
    int t;
    t = 0;
    in_data  = f;
    in_valid = 1'b1;
    while (!in_ready0 && t < 20) begin
      step();
      t++;
    end
    if (t == 20) chk1("offer_timeout", 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // Entered just after the edge that accepted the last feature of a frame.
  task automatic finish(input string name, input logic [179:0] exp, input bit use2,
                        input bit preload, input logic [17:0] nextf);
    chk1({name, "_en_bias"}, en0, 1'b0);
    chk1({name, "_rdy_bias"}, in_ready0, 1'b0);
    if (preload) begin
      in_data  = nextf;
      in_valid = 1'b1;
    end
    step();
    chk1({name, "_en_out"}, en0, 1'b0);
    chk1({name, "_rdy_out"}, in_ready0, 1'b0);
    step();
    chk1({name, "_en_pulse"}, use2 ? en2 : en0, 1'b1);
    chkv({name, "_dout"}, use2 ? dout2 : dout0, exp);
    chk1({name, "_rdy_back"}, in_ready0, 1'b1);
    step();
    in_valid = 1'b0;
    chk1({name, "_en_fall"}, en0, 1'b0);
    chkv({name, "_dout_hold"}, use2 ? dout2 : dout0, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0][17:0] exp_b;
    bit pat[7];
    bit saw_en;
    int j;

    for (int r = 0; r < 8; r++) rom[r] = '0;

    for (int i = 0; i < 5; i++) begin
      vecs[i].feat = '0; vecs[i].wt = '0; vecs[i].bias = '0;
      vecs[i].use2 = 1'b0; vecs[i].expv = '0;
    end
    for (int f = 0; f < 4; f++) vecs[0].feat[f] = 18'(f + 1);
    for (int k = 0; k < 10; k++) begin
      vecs[0].wt[k]   = 16'(k);
      vecs[0].expv[k] = 18'(10 * k);
    end
    for (int f = 0; f < 4; f++) vecs[1].feat[f] = 18'd4;
    for (int k = 0; k < 10; k++) begin
      vecs[1].wt[k]   = 16'd1;
      vecs[1].expv[k] = 18'd4;
    end
    vecs[1].bias[3] = 16'd8;
    vecs[1].bias[0] = -16'sd23;
    vecs[1].expv[3] = 18'd6;
    vecs[1].expv[0] = -18'sd2;
    vecs[1].use2    = 1'b1;
    for (int f = 0; f < 4; f++) begin
      vecs[2].feat[f] = 18'd131071;
      vecs[3].feat[f] = 18'd131071;
    end
    for (int k = 0; k < 10; k++) begin
      vecs[2].wt[k]   = 16'd32767;
      vecs[2].expv[k] = 18'd131071;
      vecs[3].wt[k]   = -16'sd32767;
      vecs[3].expv[k] = -18'sd131072;
    end
    vecs[4].feat[0] = 18'd5;
    vecs[4].feat[1] = -18'sd3;
    vecs[4].feat[2] = 18'd7;
    vecs[4].feat[3] = -18'sd2;
    for (int k = 0; k < 10; k++) begin
      vecs[4].wt[k]   = 16'(k - 5);
      vecs[4].bias[k] = 16'(250 * k - 1000);
      vecs[4].expv[k] = 18'(7 * (k - 5) + 250 * k - 1000);
    end
    for (int k = 0; k < 10; k++) exp_b[k] = 18'(26 * k);

    // reset state
    step();
    step();
    chkv("rst_dout", dout0, '0);
    chk1("rst_enable", en0, 1'b0);
    chk1("rst_ready", in_ready0, 1'b0);
    rst_n = 1'b1;
    step();
    chk1("ready_after_release", in_ready0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      load_rom(vecs[i]);
      for (int f = 0; f < 4; f++) offer(vecs[i].feat[f]);
      finish($sformatf("vec%0d", i), pack(vecs[i].expv), vecs[i].use2, 1'b0, '0);
    end

    // gapped frame, then frame B offered during BIAS/OUT and taken in the enable cycle
    load_rom(vecs[0]);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    j = 0;
    for (int p = 0; p < 7; p++) begin
      if (pat[p]) begin
        in_data  = vecs[0].feat[j];
        in_valid = 1'b1;
        j++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    finish("gaps", pack(vecs[0].expv), 1'b0, 1'b1, 18'd5);
    offer(18'd6);
    offer(18'd7);
    offer(18'd8);
    finish("frame_b", pack(exp_b), 1'b0, 1'b0, '0);

    // reset mid-frame
    offer(18'd1);
    offer(18'd2);
    rst_n = 1'b0;
    #2;
    chk1("midrst_ready", in_ready0, 1'b0);
    step();
    rst_n = 1'b1;
    chk1("midrst_en", en0, 1'b0);
    chkv("midrst_dout", dout0, '0);
    saw_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (en0) saw_en = 1'b1;
    end
    chk1("midrst_no_pulse", saw_en, 1'b0);
    for (int f = 0; f < 4; f++) offer(vecs[0].feat[f]);
    finish("post_rst", pack(vecs[0].expv), 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
